// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// and delivers {borrow_out, difference} with a one-cycle done pulse.
//
// Handshake: start is a request with no backpressure; it is accepted on any
// rising edge where the block is in IDLE or DONE (busy=0), ignored while busy=1,
// and done marks result valid for exactly one cycle (result then holds).
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 difference bits are buffered; the final bit goes straight to result.
  logic [WIDTH-2:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_comb begin
    accept     = start && ((state == IDLE) || (state == DONE));
    last_bit   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        borrow <= bin;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        borrow  <= bo_bit;
        diff_sr <= (WIDTH-1)'({d_bit, diff_sr} >> 1);
        cnt     <= cnt + 1'b1;
        if (last_bit) result <= {bo_bit, d_bit, diff_sr};
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus hand-written
// sequences for start-during-shift, mid-shift reset and back-to-back starts.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH:0]   exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;
  state_t           dbg_state;

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic scramble_operands();
    a   = WIDTH'($urandom_range(0, 255));
    b   = WIDTH'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
  endtask

  // Called at the negedge after the accept edge (n=0); returns n such that
  // done is seen in the cycle after edge accept+n. Optionally pulses start
  // with junk operands so it reaches the edge accept+poke_at+1.
  task automatic wait_done(input int poke_at, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < WIDTH + 4) begin
      if (n == poke_at) begin
        start = 1'b1;
        scramble_operands();
      end
      @(negedge clk);
      n++;
      if (n == poke_at + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vbin, input logic [WIDTH:0] exp,
                        input int poke_at, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    bin   = vbin;
    @(negedge clk);
    start = 1'b0;
    scramble_operands();
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    wait_done(poke_at, n, seen);
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(WIDTH));
    check({tag, " result"}, 32'(result), 32'(exp));
    check({tag, " busy in done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " result held"}, 32'(result), 32'(exp));
  endtask

  // scoreboard-free directed table; expected values computed by hand
  vec_t vecs [10];

  initial begin
    int n;
    bit seen;
    int pulses;

    vecs[0] = '{a: 8'd23,  b: 8'd14,  bin: 1'b0, exp: 9'd9};
    vecs[1] = '{a: 8'd11,  b: 8'd32,  bin: 1'b1, exp: 9'h1EA};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   bin: 1'b1, exp: 9'h1FF};
    vecs[3] = '{a: 8'd129, b: 8'd47,  bin: 1'b0, exp: 9'd82};
    vecs[4] = '{a: 8'd255, b: 8'd255, bin: 1'b0, exp: 9'h000};
    vecs[5] = '{a: 8'd0,   b: 8'd255, bin: 1'b0, exp: 9'h101};
    vecs[6] = '{a: 8'd255, b: 8'd0,   bin: 1'b1, exp: 9'h0FE};
    vecs[7] = '{a: 8'd200, b: 8'd100, bin: 1'b1, exp: 9'h063};
    vecs[8] = '{a: 8'd5,   b: 8'd5,   bin: 1'b1, exp: 9'h1FF};
    vecs[9] = '{a: 8'd128, b: 8'd127, bin: 1'b0, exp: 9'h001};

    // reset
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd2;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle holds", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, -1, $sformatf("vec%0d", i));

    // start pulsed during SHIFT cycle 3 must be ignored
    run_op(8'd23, 8'd14, 1'b0, 9'd9, 2, "start in shift");

    // reset mid-SHIFT aborts with no done pulse
    @(negedge clk);
    start = 1'b1;
    a     = 8'd200;
    b     = 8'd1;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort pre busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort state", 32'(dbg_state), 32'(IDLE));
    pulses = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_op(8'd255, 8'd255, 1'b0, 9'd0, -1, "after abort");

    // start held high across DONE gives two back-to-back operations
    @(negedge clk);
    start = 1'b1;
    a     = 8'd11;
    b     = 8'd32;
    bin   = 1'b1;
    @(negedge clk);
    wait_done(-1, n, seen);
    check("b2b first seen", 32'(seen), 32'd1);
    check("b2b first latency", 32'(n), 32'(WIDTH));
    check("b2b first result", 32'(result), 32'h1EA);
    a   = 8'd129;
    b   = 8'd47;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    scramble_operands();
    check("b2b gap done", 32'(done), 32'd0);
    check("b2b gap busy", 32'(busy), 32'd1);
    check("b2b first held", 32'(result), 32'h1EA);
    wait_done(-1, n, seen);
    check("b2b second seen", 32'(seen), 32'd1);
    check("b2b second latency", 32'(n), 32'(WIDTH));
    check("b2b second result", 32'(result), 32'd82);
    @(negedge clk);
    check("b2b second one pulse", 32'(done), 32'd0);
    check("b2b back to idle", 32'(dbg_state), 32'(IDLE));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
